// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Only one bus
// transaction is in flight at a time, and a wait for bus_ready is bounded by TIMEOUT.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_all
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_req_q, bus_we_q;
  logic [3:0]         bus_sel_q;
  logic [ADDR_W-1:0]  bus_addr_q;
  logic [DATA_W-1:0]  bus_wdata_q;
  logic [DATA_W-1:0]  if_rdata_q, mem_rdata_q;
  logic               if_done_q, mem_done_q, bus_err_q;
  logic               mem_go, if_go, owner_mem, timed_out;

  // A requester still holds req during its done cycle; masking it there
  // keeps a finished access from being issued a second time.
  assign mem_go    = mem_req & ~mem_done_q;
  assign if_go     = if_req & ~if_done_q;
  assign cnt_d     = cnt_q + 1'b1;
  assign timed_out = (cnt_q == CNT_LAST) & ~bus_ready;
  assign owner_mem = (state_q == MEM_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (mem_go) begin
            state_q     <= MEM_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_sel_q   <= mem_sel;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (if_go) begin
            state_q     <= IF_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b1111;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end else begin
            bus_req_q <= 1'b0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (bus_ready || timed_out) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            bus_err_q <= ~bus_ready;
            if (owner_mem) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= bus_ready ? bus_rdata : '0;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus_ready ? bus_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign bus_err   = bus_err_q;
  assign stall_all = rst & (if_go | mem_go);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences one bus transaction at a time and returns read data to the requester that issued it.
- Drives the whole-pipeline freeze request (stall_all) into the pipeline controller until every pending access has completed.
- Sits between the IF/MEM stages and the external SRAM/bus interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for bus_ready before aborting. Must be ≥1 and fit in the timeout counter.
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_done  out  1  one-cycle completion pulse for fetch.
- mem_req  in  1  data access request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; registered.
- mem_done  out  1  one-cycle completion pulse for data access.
- bus_err  out  1  high together with a done pulse when that access timed out.
- bus_req  out  1  transaction valid on the bus.
- bus_we  out  1  bus write enable.
- bus_sel  out  4  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_ready  in  1  bus completes the current transaction in this cycle.
- bus_rdata  in  DATA_W  read data, valid when bus_ready = 1.
- stall_all  out  1  freeze request to the pipeline controller.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State returns to IDLE.
  - All registered outputs clear to 0: bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, bus_err.
  - Timeout counter clears to 0.
  - stall_all is forced to 0 while rst = 0.
  - Reset mid-transaction abandons the transaction; no done pulse is issued.
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - mem_req = 1: latch mem_addr, mem_we, mem_sel and mem_wdata into the bus registers, go to MEM_BUSY. mem_req has priority because it belongs to the older instruction.
  - Otherwise, if_req = 1: latch if_addr, with bus_we = 0 and bus_sel = 4'b1111, go to IF_BUSY.
  - Otherwise stay in IDLE with bus_req = 0.
- BUSY states:
  - bus_req = 1 and the bus registers are stable for the whole transaction.
  - The timeout counter increments once per cycle while bus_ready = 0.
- Completion (bus_ready = 1 while busy):
  - Next cycle: the owning requester's rdata register loads bus_rdata. Store data is don't-care, but the register is still loaded.
  - The owning requester's done pulses for exactly 1 cycle with bus_err = 0.
  - State returns to IDLE and bus_req drops to 0.
- Timeout (counter reaches TIMEOUT with bus_ready still 0):
  - Next cycle: the owner's done = 1, bus_err = 1, the owner's rdata = 0.
  - bus_req = 0, state returns to IDLE.
- Latency: request seen in IDLE at cycle 0 → bus_req = 1 at cycle 1. bus_ready at cycle n → done at cycle n+1.
- Back-to-back requests: IDLE always lasts at least one cycle between transactions, so each access costs at least 3 cycles.
- Simultaneous requests: mem is served first. if_req stays pending and is granted on the IDLE cycle after mem_done.
- Requester drops its req mid-transaction: the transaction still completes, and its done pulse is issued normally.
- A request arriving while busy waits. It is never pre-empted and never causes the in-flight transaction to be re-issued.
- stall_all = rst & ((if_req & ~if_done) | (mem_req & ~mem_done)). This is combinational, so the pipeline advances on the done cycle.
- bus_ready while in IDLE is ignored.

Test Plan:
- Reset, then idle with no requests → all outputs 0 and stall_all = 0. Assert rst = 0 mid-MEM_BUSY → bus_req = 0 immediately and no mem_done.
- if_req with if_addr = 0x0040_0010, bus_ready 2 cycles after bus_req, bus_rdata = 0x2402_0005 → bus_addr = 0x0040_0010, bus_we = 0, if_done for 1 cycle with if_rdata = 0x2402_0005, stall_all high until the done cycle.
- if_req and mem_req in the same cycle, mem store to addr 0x1000_0004 with sel = 4'b0011 and wdata = 0xDEAD_BEEF, zero-wait ready → store issued first, mem_done, one IDLE cycle, then fetch issued and if_done.
- Load with bus_ready held low and TIMEOUT = 4 → mem_done = 1 with bus_err = 1 and mem_rdata = 0 after the 4-cycle timeout expires. A subsequent fetch then completes normally with bus_err = 0.
- mem_req dropped one cycle after grant → transaction completes on bus_ready and mem_done still pulses. No re-issue occurs.
- if_req arriving while MEM_BUSY → bus_addr stays on the mem address until mem_done. Fetch starts exactly one cycle after the IDLE cycle.
